// File: rtl/chunked_subtractor_if.sv
// ============================================================================
// Module   : chunked_subtractor_if
// Brief    : Operand/result handshake bundle for chunked_subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chunked_subtractor_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         borrow;
    logic         overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  D,
        input  borrow,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output D,
        output borrow,
        output overflow
    );
endinterface

`default_nettype wire

// File: rtl/chunked_subtractor.sv
// ============================================================================
// Module   : chunked_subtractor
// Brief    : Multi-cycle D = a - b, W bits per cycle LSB first, valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunked_subtractor #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    chunked_subtractor_if.slave  bus
);

    localparam int              c_NUM_CHUNKS = N / W;
    localparam int              c_CNT_W      = (c_NUM_CHUNKS > 1) ? $clog2(c_NUM_CHUNKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CHUNK = c_CNT_W'(c_NUM_CHUNKS - 1);
    localparam logic [N-1:0]    c_CHUNK_MASK = N'({W{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [N-1:0]         a_q,         a_d;
    logic [N-1:0]         b_q,         b_d;
    logic [N-1:0]         res_q,       res_d;
    logic [c_CNT_W-1:0]   cnt_q,       cnt_d;
    logic                 carry_q,     carry_d;
    logic [N-1:0]         dout_q,      dout_d;
    logic                 borrow_q,    borrow_d;
    logic                 ovf_q,       ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic [31:0]          w_shift;
    logic [W-1:0]         w_a_chunk;
    logic [W-1:0]         w_b_chunk;
    logic [W-1:0]         w_sum;
    logic                 w_carry_out;
    logic [N-1:0]         w_result_next;

    // One W-bit slice of a + ~b + 1; the +1 enters as the initial carry.
    assign w_shift   = 32'(cnt_q) * 32'(W);
    assign w_a_chunk = W'(a_q >> w_shift);
    assign w_b_chunk = W'(b_q >> w_shift);
    assign {w_carry_out, w_sum} = {1'b0, w_a_chunk} + {1'b0, ~w_b_chunk}
                                + {{W{1'b0}}, carry_q};
    assign w_result_next = (res_q & ~(c_CHUNK_MASK << w_shift))
                         | (N'(w_sum) << w_shift);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        dout_d      = dout_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_d   = w_result_next;
                carry_d = w_carry_out;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_LAST_CHUNK) begin
                    // Outputs are loaded only here, so partial results never reach D.
                    dout_d      = w_result_next;
                    borrow_d    = ~w_carry_out;
                    ovf_d       = (a_q[N-1] ^ b_q[N-1]) & (w_result_next[N-1] ^ a_q[N-1]);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            dout_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            dout_q      <= dout_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.D         = dout_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_chunked_subtractor.sv
// ============================================================================
// Module   : tb_chunked_subtractor
// Brief    : Directed checks of chunked_subtractor at W = 8, 1 and 32 in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunked_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;

    int n_checks = 0;
    int n_errors = 0;

    // Index 0: W=8, index 1: W=1, index 2: W=32
    int wid[3]     = '{8, 1, 32};
    int lat_exp[3] = '{4, 32, 1};

    always #5 clk = ~clk;

    chunked_subtractor_if #(.N(32)) bus_w8  ();
    chunked_subtractor_if #(.N(32)) bus_w1  ();
    chunked_subtractor_if #(.N(32)) bus_w32 ();

    assign bus_w8.in_valid   = in_valid;
    assign bus_w8.a          = a_drv;
    assign bus_w8.b          = b_drv;
    assign bus_w8.out_ready  = out_ready;
    assign bus_w1.in_valid   = in_valid;
    assign bus_w1.a          = a_drv;
    assign bus_w1.b          = b_drv;
    assign bus_w1.out_ready  = out_ready;
    assign bus_w32.in_valid  = in_valid;
    assign bus_w32.a         = a_drv;
    assign bus_w32.b         = b_drv;
    assign bus_w32.out_ready = out_ready;

    chunked_subtractor #(.N(32), .W(8))  u_dut_w8  (.clk(clk), .rst_n(rst_n), .bus(bus_w8));
    chunked_subtractor #(.N(32), .W(1))  u_dut_w1  (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
    chunked_subtractor #(.N(32), .W(32)) u_dut_w32 (.clk(clk), .rst_n(rst_n), .bus(bus_w32));

    logic [2:0]  ov, ir, bo, of;
    logic [31:0] dv [3];

    assign ov    = {bus_w32.out_valid, bus_w1.out_valid, bus_w8.out_valid};
    assign ir    = {bus_w32.in_ready,  bus_w1.in_ready,  bus_w8.in_ready};
    assign bo    = {bus_w32.borrow,    bus_w1.borrow,    bus_w8.borrow};
    assign of    = {bus_w32.overflow,  bus_w1.overflow,  bus_w8.overflow};
    assign dv[0] = bus_w8.D;
    assign dv[1] = bus_w1.D;
    assign dv[2] = bus_w32.D;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int j = 0; j < 3; j++) begin
            chk_eq($sformatf("%s_out_valid_w%0d", tag, wid[j]), 32'(ov[j]), 32'd0);
            chk_eq($sformatf("%s_D_w%0d",         tag, wid[j]), dv[j],      32'd0);
            chk_eq($sformatf("%s_borrow_w%0d",    tag, wid[j]), 32'(bo[j]), 32'd0);
            chk_eq($sformatf("%s_overflow_w%0d",  tag, wid[j]), 32'(of[j]), 32'd0);
            chk_eq($sformatf("%s_in_ready_w%0d",  tag, wid[j]), 32'(ir[j]), 32'd1);
        end
    endtask

    // Leaves the caller at accept edge + 1 time unit.
    task automatic start_op(input string tag, input logic [31:0] ta, input logic [31:0] tb);
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++)
            chk_eq($sformatf("%s_ready_before_w%0d", tag, wid[j]), 32'(ir[j]), 32'd1);
        a_drv    = ta;
        b_drv    = tb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++)
            chk_eq($sformatf("%s_busy_w%0d", tag, wid[j]), 32'(ir[j]), 32'd0);
    endtask

    task automatic wait_check(input string tag, input logic [31:0] exp_d,
                              input logic exp_b, input logic exp_o);
        int lat[3] = '{-1, -1, -1};
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++)
                if (ov[j] && lat[j] < 0) lat[j] = c;
            if (lat[0] > 0 && lat[1] > 0 && lat[2] > 0) break;
        end
        for (int j = 0; j < 3; j++) begin
            chk_eq($sformatf("%s_latency_w%0d",  tag, wid[j]), 32'(lat[j]), 32'(lat_exp[j]));
            chk_eq($sformatf("%s_D_w%0d",        tag, wid[j]), dv[j],       exp_d);
            chk_eq($sformatf("%s_borrow_w%0d",   tag, wid[j]), 32'(bo[j]),  32'(exp_b));
            chk_eq($sformatf("%s_overflow_w%0d", tag, wid[j]), 32'(of[j]),  32'(exp_o));
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk_eq($sformatf("%s_valid_drop_w%0d", tag, wid[j]), 32'(ov[j]), 32'd0);
            chk_eq($sformatf("%s_idle_w%0d",       tag, wid[j]), 32'(ir[j]), 32'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [31:0] exp_d, input logic exp_b, input logic exp_o);
        start_op(tag, ta, tb);
        wait_check(tag, exp_d, exp_b, exp_o);
        release_result(tag);
    endtask

    // Called at posedge + 1; asserts reset mid-cycle and releases on the next negedge.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_state(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_drv     = '0;
        b_drv     = '0;
        #1 rst_n  = 1'b0;
        #1 check_reset_state("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("basic",    32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);
        run_op("xborrow",  32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0);
        run_op("wrap",     32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("equal",    32'hAFFF_FFFF, 32'hAFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        run_op("ovf_neg",  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("ovf_pos",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);

        // Backpressure: result held while new operands wait on the input side
        start_op("bp", 32'h0000_FFFF, 32'h0000_0001);
        wait_check("bp", 32'h0000_FFFE, 1'b0, 1'b0);
        a_drv    = 32'h0000_0010;
        b_drv    = 32'h0000_0020;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) begin
                chk_eq($sformatf("bp_hold_valid_w%0d", wid[j]), 32'(ov[j]), 32'd1);
                chk_eq($sformatf("bp_hold_D_w%0d",     wid[j]), dv[j],      32'h0000_FFFE);
                chk_eq($sformatf("bp_hold_ready_w%0d", wid[j]), 32'(ir[j]), 32'd0);
            end
        end
        release_result("bp");
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++)
            chk_eq($sformatf("bp_accept_w%0d", wid[j]), 32'(ir[j]), 32'd0);
        wait_check("bp_next", 32'hFFFF_FFF0, 1'b1, 1'b0);

        // Reset while results are held in DONE
        reset_pulse("rst_done");

        // Reset two cycles into the calculation; no result may appear afterwards
        start_op("abort", 32'hFFFF_FFFF, 32'h0000_0001);
        repeat (2) @(posedge clk);
        #1;
        reset_pulse("rst_calc");
        begin
            logic [2:0] seen = 3'b000;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                seen = seen | ov;
            end
            for (int j = 0; j < 3; j++)
                chk_eq($sformatf("abort_no_valid_w%0d", wid[j]), 32'(seen[j]), 32'd0);
        end

        run_op("post_rst", 32'h1234_5678, 32'h0234_5678, 32'h1000_0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
